// File: rtl/dlcmsm_mvc.sv
// -----------------------------------------------------------------------------
// dlcmsm_mvc : PCIe Data Link Control and Management State Machine with
// multi-VC flow-control initialisation.
//
// Tracks the InitFC1 / InitFC2 exchange for every (VC, credit type) pair and
// schedules outgoing InitFC DLLPs to the DLLP transmit arbiter through a
// req/ack handshake. Reports DL_Up / DL_Down to the Transaction Layer.
//
// Parameters:
//   NUM_VC      number of virtual channels (1..8)
//   RESEND_CYC  idle cycles between complete InitFC sets (timer build only)
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   link_up_i               physical LinkUp from the LTSSM
//   rx_fc1_vld_i            InitFC1 DLLP received (pulse)
//   rx_fc2_vld_i            InitFC2 DLLP received (pulse)
//   rx_upd_vld_i            UpdateFC DLLP or TLP received (pulse)
//   rx_vc_i, rx_type_i      VC and credit type (0=P,1=NP,2=Cpl) of rx item
//   tx_req_o                InitFC DLLP transmit request
//   tx_fc2_o                0=InitFC1, 1=InitFC2
//   tx_vc_o, tx_type_o      VC and credit type of the requested DLLP
//   tx_ack_i                arbiter accepted the request this cycle
//   state_o                 00 INACTIVE, 01 INIT1, 10 INIT2, 11 ACTIVE
//   dl_up_o, dl_down_o      decoded ACTIVE / INACTIVE
//
// Build option:
//   DLCMSM_RESEND_TIMER_EN  when defined, RESEND_CYC idle cycles separate
//                           repeated InitFC sets; otherwise sets run
//                           back-to-back.
// -----------------------------------------------------------------------------
module dlcmsm_mvc #(
  parameter int NUM_VC     = 1,
  parameter int RESEND_CYC = 256
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       link_up_i,
  input  logic       rx_fc1_vld_i,
  input  logic       rx_fc2_vld_i,
  input  logic       rx_upd_vld_i,
  input  logic [2:0] rx_vc_i,
  input  logic [1:0] rx_type_i,
  output logic       tx_req_o,
  output logic       tx_fc2_o,
  output logic [2:0] tx_vc_o,
  output logic [1:0] tx_type_o,
  input  logic       tx_ack_i,
  output logic [1:0] state_o,
  output logic       dl_up_o,
  output logic       dl_down_o
);

  localparam int NE = NUM_VC * 3;
  // An illegal parameter set keeps the link reported as down.
  localparam logic CFG_OK = ((NUM_VC >= 1) && (NUM_VC <= 8) && (RESEND_CYC >= 1)) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    ST_INACTIVE = 2'b00,
    ST_INIT1    = 2'b01,
    ST_INIT2    = 2'b10,
    ST_ACTIVE   = 2'b11
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [NE-1:0]   r_fc1;
  logic [NE-1:0]   r_fc2;
  logic [NE-1:0]   w_rx_hit;
  logic [NE-1:0]   w_fc1_nxt;
  logic [NE-1:0]   w_fc2_nxt;
  logic            r_sent;
  logic            w_sent_nxt;
  logic            w_ack;
  logic            w_last;
  logic            w_rx_ok;
  logic            w_link;
  logic [4:0]      w_rx_idx;
  logic [2:0]      w_vc_nxt;
  logic [1:0]      w_type_nxt;
  logic            r_tx_req;
  logic            r_tx_fc2;
  logic [2:0]      r_tx_vc;
  logic [1:0]      r_tx_type;
  logic            r_dl_up;
  logic            r_dl_down;

`ifdef DLCMSM_RESEND_TIMER_EN
  localparam int GW = $clog2(RESEND_CYC + 1);
  logic [GW-1:0]   r_gap;
`endif

  assign w_link     = link_up_i & CFG_OK;
  assign w_ack      = r_tx_req & tx_ack_i;
  // The tx fields double as the scheduler index.
  assign w_last     = (r_tx_vc == 3'(NUM_VC - 1)) && (r_tx_type == 2'd2);
  assign w_rx_ok    = ({1'b0, rx_vc_i} < 4'(NUM_VC)) && (rx_type_i != 2'd3);
  assign w_rx_idx   = ({2'b00, rx_vc_i} * 5'd3) + {3'b000, rx_type_i};
  assign w_fc1_nxt  = r_fc1 | (w_rx_hit & {NE{rx_fc1_vld_i | rx_fc2_vld_i}});
  assign w_fc2_nxt  = r_fc2 | (w_rx_hit & {NE{rx_fc2_vld_i | rx_upd_vld_i}});
  // Ack of the final entry counts toward completion in the same cycle.
  assign w_sent_nxt = r_sent | (w_ack & w_last);

  // One-hot decode of the received (vc,type) into the flag vector
  always_comb begin
    w_rx_hit = {NE{1'b0}};
    for (int i = 0; i < NE; i++) begin
      if (w_rx_ok && (w_rx_idx == 5'(i))) begin
        w_rx_hit[i] = 1'b1;
      end else begin
        w_rx_hit[i] = 1'b0;
      end
    end
  end

  // Scheduler index successor: P, NP, Cpl per VC, wrapping after the last VC
  always_comb begin
    w_vc_nxt   = r_tx_vc;
    w_type_nxt = r_tx_type;
    if (w_last) begin
      w_vc_nxt   = 3'd0;
      w_type_nxt = 2'd0;
    end else if (r_tx_type == 2'd2) begin
      w_vc_nxt   = r_tx_vc + 3'd1;
      w_type_nxt = 2'd0;
    end else begin
      w_type_nxt = r_tx_type + 2'd1;
    end
  end

  // Next-state decode; link loss overrides every other transition
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_INACTIVE: begin
        if (w_link) w_state_nxt = ST_INIT1;
        else        w_state_nxt = ST_INACTIVE;
      end
      ST_INIT1: begin
        if (!w_link)                         w_state_nxt = ST_INACTIVE;
        else if ((&w_fc1_nxt) && w_sent_nxt) w_state_nxt = ST_INIT2;
        else                                 w_state_nxt = ST_INIT1;
      end
      ST_INIT2: begin
        if (!w_link)                         w_state_nxt = ST_INACTIVE;
        else if ((&w_fc2_nxt) && w_sent_nxt) w_state_nxt = ST_ACTIVE;
        else                                 w_state_nxt = ST_INIT2;
      end
      ST_ACTIVE: begin
        if (!w_link) w_state_nxt = ST_INACTIVE;
        else         w_state_nxt = ST_ACTIVE;
      end
      default: w_state_nxt = ST_INACTIVE;
    endcase
  end

  // State register, flag tracking, InitFC scheduler and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_INACTIVE;
      r_fc1     <= {NE{1'b0}};
      r_fc2     <= {NE{1'b0}};
      r_sent    <= 1'b0;
      r_tx_req  <= 1'b0;
      r_tx_fc2  <= 1'b0;
      r_tx_vc   <= 3'd0;
      r_tx_type <= 2'd0;
      r_dl_up   <= 1'b0;
      r_dl_down <= 1'b1;
`ifdef DLCMSM_RESEND_TIMER_EN
      r_gap     <= {GW{1'b0}};
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_dl_up   <= (w_state_nxt == ST_ACTIVE);
      r_dl_down <= (w_state_nxt == ST_INACTIVE);
      if (w_state_nxt != r_state) begin
        // Any state change withdraws the request and restarts the set.
        r_fc1     <= {NE{1'b0}};
        r_fc2     <= {NE{1'b0}};
        r_sent    <= 1'b0;
        r_tx_req  <= 1'b0;
        r_tx_fc2  <= (w_state_nxt == ST_INIT2);
        r_tx_vc   <= 3'd0;
        r_tx_type <= 2'd0;
`ifdef DLCMSM_RESEND_TIMER_EN
        r_gap     <= {GW{1'b0}};
`endif
      end else if ((r_state == ST_INIT1) || (r_state == ST_INIT2)) begin
        if (r_state == ST_INIT1) begin
          r_fc1 <= w_fc1_nxt;
        end else begin
          r_fc2 <= w_fc2_nxt;
        end
        r_sent <= w_sent_nxt;
        if (w_ack) begin
          r_tx_vc   <= w_vc_nxt;
          r_tx_type <= w_type_nxt;
`ifdef DLCMSM_RESEND_TIMER_EN
          if (w_last) begin
            r_tx_req <= 1'b0;
            r_gap    <= GW'(RESEND_CYC);
          end else begin
            r_tx_req <= 1'b1;
          end
`else
          r_tx_req  <= 1'b1;
`endif
        end else if (!r_tx_req) begin
`ifdef DLCMSM_RESEND_TIMER_EN
          // Request returns in the cycle after the counter's last idle cycle.
          if (r_gap == {GW{1'b0}}) begin
            r_tx_req <= 1'b1;
          end else begin
            r_gap    <= r_gap - GW'(1);
            r_tx_req <= (r_gap == GW'(1));
          end
`else
          r_tx_req <= 1'b1;
`endif
        end else begin
          r_tx_req <= 1'b1;
        end
      end else begin
        r_fc1    <= {NE{1'b0}};
        r_fc2    <= {NE{1'b0}};
        r_sent   <= 1'b0;
        r_tx_req <= 1'b0;
`ifdef DLCMSM_RESEND_TIMER_EN
        r_gap    <= {GW{1'b0}};
`endif
      end
    end
  end

  assign tx_req_o  = r_tx_req;
  assign tx_fc2_o  = r_tx_fc2;
  assign tx_vc_o   = r_tx_vc;
  assign tx_type_o = r_tx_type;
  assign state_o   = r_state;
  assign dl_up_o   = r_dl_up;
  assign dl_down_o = r_dl_down;

endmodule

// File: tb/tb_dlcmsm_mvc.sv
// -----------------------------------------------------------------------------
// tb_dlcmsm_mvc : scoreboard bench for dlcmsm_mvc (NUM_VC=2, RESEND_CYC=4).
// Stimulus pushes expected InitFC requests and state changes into queues;
// monitors pop and compare whenever the DUT accepts a request or changes state.
// -----------------------------------------------------------------------------
module tb_dlcmsm_mvc;

`ifdef DLCMSM_RESEND_TIMER_EN
  localparam int EXP_GAP = 4;
`else
  localparam int EXP_GAP = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       link_up_i;
  logic       rx_fc1_vld_i;
  logic       rx_fc2_vld_i;
  logic       rx_upd_vld_i;
  logic [2:0] rx_vc_i;
  logic [1:0] rx_type_i;
  logic       tx_req_o;
  logic       tx_fc2_o;
  logic [2:0] tx_vc_o;
  logic [1:0] tx_type_o;
  logic       tx_ack_i;
  logic [1:0] state_o;
  logic       dl_up_o;
  logic       dl_down_o;

  int total = 0;
  int bad   = 0;

  logic [5:0] exp_tx[$];
  logic [1:0] exp_st[$];
  logic [1:0] prev_state = 2'd0;

  dlcmsm_mvc #(.NUM_VC(2), .RESEND_CYC(4)) dut (
    .clk(clk), .rst_n(rst_n), .link_up_i(link_up_i),
    .rx_fc1_vld_i(rx_fc1_vld_i), .rx_fc2_vld_i(rx_fc2_vld_i),
    .rx_upd_vld_i(rx_upd_vld_i), .rx_vc_i(rx_vc_i), .rx_type_i(rx_type_i),
    .tx_req_o(tx_req_o), .tx_fc2_o(tx_fc2_o), .tx_vc_o(tx_vc_o),
    .tx_type_o(tx_type_o), .tx_ack_i(tx_ack_i), .state_o(state_o),
    .dl_up_o(dl_up_o), .dl_down_o(dl_down_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [5:0] ent(input bit fc2, input int vc, input int ty);
    return {fc2, 3'(vc), 2'(ty)};
  endfunction

  task automatic push_set(input bit fc2);
    for (int v = 0; v < 2; v++)
      for (int t = 0; t < 3; t++)
        exp_tx.push_back(ent(fc2, v, t));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int kind, input int vc, input int ty);
    rx_vc_i   = 3'(vc);
    rx_type_i = 2'(ty);
    rx_fc1_vld_i = (kind == 1);
    rx_fc2_vld_i = (kind == 2);
    rx_upd_vld_i = (kind == 3);
    tick();
    rx_fc1_vld_i = 1'b0;
    rx_fc2_vld_i = 1'b0;
    rx_upd_vld_i = 1'b0;
  endtask

  // Request scoreboard: every accepted InitFC request must match the queue head
  always @(negedge clk) begin
    if (rst_n && tx_req_o && tx_ack_i) begin
      if (exp_tx.size() == 0) begin
        chk("unexpected_tx_accept", int'({tx_fc2_o, tx_vc_o, tx_type_o}), -1);
      end else begin
        chk("tx_accept", int'({tx_fc2_o, tx_vc_o, tx_type_o}), int'(exp_tx.pop_front()));
      end
    end
  end

  // State scoreboard: every state change must match the queue head
  always @(negedge clk) begin
    logic [1:0] e;
    if (rst_n && (state_o != prev_state)) begin
      if (exp_st.size() == 0) begin
        chk("unexpected_state", int'(state_o), -1);
      end else begin
        e = exp_st.pop_front();
        chk("state_change", int'(state_o), int'(e));
        chk("dl_up_on_change", int'(dl_up_o), (e == 2'd3) ? 1 : 0);
        chk("dl_down_on_change", int'(dl_down_o), (e == 2'd0) ? 1 : 0);
      end
      prev_state = state_o;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    int w;
    rst_n = 1'b0; link_up_i = 1'b0; tx_ack_i = 1'b0;
    rx_fc1_vld_i = 1'b0; rx_fc2_vld_i = 1'b0; rx_upd_vld_i = 1'b0;
    rx_vc_i = 3'd0; rx_type_i = 2'd0;
    tick(); tick();
    chk("rst_state", int'(state_o), 0);
    chk("rst_req", int'(tx_req_o), 0);
    chk("rst_fc2", int'(tx_fc2_o), 0);
    chk("rst_vc", int'(tx_vc_o), 0);
    chk("rst_type", int'(tx_type_o), 0);
    chk("rst_dl_up", int'(dl_up_o), 0);
    chk("rst_dl_down", int'(dl_down_o), 1);
    rst_n = 1'b1;
    tick();

    // Phase A: INIT1 with ack tied high, two sets and the inter-set gap
    link_up_i = 1'b1; tx_ack_i = 1'b1;
    exp_st.push_back(2'd1);
    tick();
    chk("init1_req_not_yet", int'(tx_req_o), 0);
    push_set(1'b0);
    push_set(1'b0);
    tick();
    chk("init1_req_rise", int'(tx_req_o), 1);
    repeat (5) tick();
    g = 0;
    tick();
    while (!tx_req_o && g < 20) begin
      g++;
      tick();
    end
    chk("resend_gap", g, EXP_GAP);
    repeat (5) tick();
    tick();
    tx_ack_i = 1'b0;

    // Hold test: request and fields stable for 10 cycles without ack
    w = 0;
    while (!tx_req_o && w < 20) begin
      w++;
      tick();
    end
    chk("hold_req_present", int'(tx_req_o), 1);
    for (int k = 0; k < 10; k++) begin
      chk("hold_fields", int'({tx_req_o, tx_fc2_o, tx_vc_o, tx_type_o}), int'({1'b1, ent(1'b0, 0, 0)}));
      tick();
    end
    exp_tx.push_back(ent(1'b0, 0, 0));
    tx_ack_i = 1'b1;
    tick();
    tx_ack_i = 1'b0;
    chk("advance_after_ack", int'({tx_req_o, tx_fc2_o, tx_vc_o, tx_type_o}), int'({1'b1, ent(1'b0, 0, 1)}));

    // Link loss mid-request
    link_up_i = 1'b0;
    exp_st.push_back(2'd0);
    tick();
    chk("drop_state", int'(state_o), 0);
    chk("drop_dl_down", int'(dl_down_o), 1);
    chk("drop_req", int'(tx_req_o), 0);

    // Phase B: relink, inject InitFC1 flags (plus illegal ones) before sending
    link_up_i = 1'b1;
    exp_st.push_back(2'd1);
    tick();
    pulse(1, 0, 0);
    pulse(2, 0, 1);
    pulse(1, 0, 2);
    pulse(1, 1, 1);
    pulse(2, 1, 2);
    pulse(1, 0, 3);
    pulse(1, 5, 0);
    pulse(2, 2, 1);
    chk("illegal_rx_stay_init1", int'(state_o), 1);
    pulse(1, 1, 0);
    chk("flags_done_unsent_init1", int'(state_o), 1);
    chk("held_first_req", int'({tx_req_o, tx_fc2_o, tx_vc_o, tx_type_o}), int'({1'b1, ent(1'b0, 0, 0)}));
    push_set(1'b0);
    exp_st.push_back(2'd2);
    tx_ack_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i == 5) begin
        rx_fc2_vld_i = 1'b1; rx_vc_i = 3'd0; rx_type_i = 2'd0;
      end
      tick();
      rx_fc2_vld_i = 1'b0;
    end
    chk("init2_entry", int'(state_o), 2);
    chk("init2_entry_req_drop", int'(tx_req_o), 0);
    push_set(1'b1);
    tick();
    chk("init2_first_req", int'({tx_req_o, tx_fc2_o, tx_vc_o, tx_type_o}), int'({1'b1, ent(1'b1, 0, 0)}));
    pulse(3, 0, 1);
    pulse(3, 0, 2);
    pulse(2, 1, 0);
    pulse(3, 1, 1);
    pulse(3, 1, 2);
    tick();
    tx_ack_i = 1'b0;
    chk("entry_rx_lost_init2", int'(state_o), 2);
    exp_st.push_back(2'd3);
    pulse(2, 0, 0);
    chk("active_state", int'(state_o), 3);
    chk("active_dl_up", int'(dl_up_o), 1);
    chk("active_req", int'(tx_req_o), 0);

    // Phase C: no requests in ACTIVE, then link loss and relink with clear flags
    tx_ack_i = 1'b1;
    repeat (3) tick();
    chk("active_no_req", int'(tx_req_o), 0);
    tx_ack_i = 1'b0;
    link_up_i = 1'b0;
    exp_st.push_back(2'd0);
    tick();
    chk("drop2_dl_down", int'(dl_down_o), 1);
    chk("drop2_req", int'(tx_req_o), 0);
    link_up_i = 1'b1;
    exp_st.push_back(2'd1);
    tick();
    tx_ack_i = 1'b1;
    push_set(1'b0);
    repeat (6) tick();
    tick();
    tx_ack_i = 1'b0;
    chk("relink_flags_clear", int'(state_o), 1);
    tick(); tick();
    chk("tx_queue_drained", exp_tx.size(), 0);
    chk("state_queue_drained", exp_st.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
